// File: rtl/uart_rx_loader.sv
// 8N1 UART receiver that packs every four good bytes little-endian into a
// 32-bit word and offers it on a valid/ready write port with an auto-incrementing address.
module uart_rx_loader #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int ADDR_WIDTH    = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    input  logic                  load_start,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic [7:0]            rx_byte,
    output logic                  rx_byte_valid,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);
    localparam int DIV  = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_C  = CW'(DIV);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                state_r, state_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic [2:0]            bit_idx_r, bit_idx_s;
    logic [7:0]            shift_r, shift_s;
    logic                  sync1_r, sync2_r;
    logic                  good_s, ferr_s, expire_s, complete_s, hs_s;
    logic [1:0]            phase_r;
    logic [31:0]           buf_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  wr_valid_r, overrun_r, rx_byte_valid_r, frame_err_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [31:0]           wr_data_r;
    logic [7:0]            rx_byte_r;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Receiver state, bit timer, bit index and data shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
        end
    end

    assign expire_s = (cnt_r <= CW'(1));

    // Receiver next-state: samples are taken when the bit timer reaches 1.
    always_comb begin
        state_s   = state_r;
        cnt_s     = (cnt_r != {CW{1'b0}}) ? cnt_r - CW'(1) : cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        good_s    = 1'b0;
        ferr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!sync2_r) begin
                    state_s = START;
                    cnt_s   = HALF_C;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (expire_s) begin
                    if (!sync2_r) begin
                        state_s   = DATA;
                        bit_idx_s = 3'd0;
                        cnt_s     = DIV_C;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (expire_s) begin
                    shift_s   = {sync2_r, shift_r[7:1]};
                    cnt_s     = DIV_C;
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (expire_s) begin
                    if (sync2_r) begin
                        good_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = WAIT_HIGH;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAIT_HIGH: begin
                if (sync2_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_HIGH;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign complete_s = good_s && (phase_r == 2'd3);
    assign hs_s       = wr_valid_r && wr_ready;

    // Byte status pulses and the displayed byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte_r       <= 8'h00;
            rx_byte_valid_r <= 1'b0;
            frame_err_r     <= 1'b0;
        end else begin
            rx_byte_valid_r <= good_s;
            frame_err_r     <= ferr_s;
            if (good_s) begin
                rx_byte_r <= shift_r;
            end
        end
    end

    // Word assembler, write port and overrun tracking; load_start wins over everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r    <= 2'd0;
            buf_r      <= 32'h0000_0000;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            wr_valid_r <= 1'b0;
            wr_addr_r  <= {ADDR_WIDTH{1'b0}};
            wr_data_r  <= 32'h0000_0000;
            overrun_r  <= 1'b0;
        end else if (load_start) begin
            phase_r    <= 2'd0;
            buf_r      <= 32'h0000_0000;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            wr_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (good_s) begin
                buf_r[{phase_r, 3'b000} +: 8] <= shift_r;
                phase_r <= phase_r + 2'd1;
            end
            if (hs_s) begin
                addr_r <= addr_r + ADDR_WIDTH'(1);
            end
            if (complete_s) begin
                if (!wr_valid_r || hs_s) begin
                    wr_data_r  <= {shift_r, buf_r[23:0]};
                    wr_addr_r  <= hs_s ? addr_r + ADDR_WIDTH'(1) : addr_r;
                    wr_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (hs_s) begin
                wr_valid_r <= 1'b0;
            end
        end
    end

    assign wr_valid      = wr_valid_r;
    assign wr_addr       = wr_addr_r;
    assign wr_data       = wr_data_r;
    assign rx_byte       = rx_byte_r;
    assign rx_byte_valid = rx_byte_valid_r;
    assign frame_err     = frame_err_r;
    assign overrun       = overrun_r;
    assign busy          = (state_r != IDLE) || wr_valid_r;
endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader: bytes and words are queued as expected when sent
// and popped by a negedge monitor when the DUT reports them.
module tb_uart_rx_loader;
    localparam int DIV = 16;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          reset_n, rx, load_start, wr_ready;
    logic          wr_valid, rx_byte_valid, frame_err, overrun, busy;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [7:0]    rx_byte;

    int vectors = 0, miscompares = 0;
    int byte_pulses = 0, ferr_pulses = 0, handshakes = 0;
    logic [7:0]      exp_bytes[$];
    logic [AW+31:0]  exp_words[$];

    uart_rx_loader #(.CLK_FREQUENCY(1600), .BAUD_RATE(100), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .load_start(load_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_byte_valid || frame_err)
                check("pulse_exclusive", {63'd0, rx_byte_valid & frame_err}, 64'd0);
            if (frame_err) ferr_pulses++;
            if (rx_byte_valid) begin
                byte_pulses++;
                if (exp_bytes.size() == 0)
                    check("byte_unexpected", {56'd0, rx_byte}, 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    check("rx_byte", {56'd0, rx_byte}, {56'd0, exp_bytes.pop_front()});
            end
            if (wr_valid && wr_ready) begin
                handshakes++;
                if (exp_words.size() == 0)
                    check("word_unexpected", {30'd0, wr_addr, wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    check("word", {30'd0, wr_addr, wr_data}, {30'd0, exp_words.pop_front()});
            end
        end
    end

    task automatic bit_out(input logic v);
        rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_bytes.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"}, {27'd0, wr_valid, rx_byte_valid, frame_err, overrun, busy,
               wr_addr, rx_byte, wr_data}, 64'd0);
    endtask

    initial begin
        int b0, f0, h0;
        reset_n = 1'b0; rx = 1'b1; load_start = 1'b0; wr_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Single word with the consumer always ready.
        wr_ready = 1'b1;
        b0 = byte_pulses; h0 = handshakes;
        exp_words.push_back({2'd0, 32'h1234_5678});
        send_good(8'h78); send_good(8'h56); send_good(8'h34); send_good(8'h12);
        repeat (4) @(posedge clk); #1;
        check("single_byte_pulses", 64'(byte_pulses - b0), 64'd4);
        check("single_handshakes", 64'(handshakes - h0), 64'd1);
        check("single_wr_valid_low", {63'd0, wr_valid}, 64'd0);

        // Start-bit glitch shorter than half a bit.
        b0 = byte_pulses; f0 = ferr_pulses;
        rx = 1'b0; repeat (3) @(posedge clk); #1;
        rx = 1'b1; repeat (3 * DIV) @(posedge clk); #1;
        check("glitch_no_byte", 64'(byte_pulses - b0), 64'd0);
        check("glitch_no_ferr", 64'(ferr_pulses - f0), 64'd0);
        check("glitch_idle", {63'd0, busy}, 64'd0);

        // Framing error, then a good byte that must land in phase 0 of address 1.
        b0 = byte_pulses; f0 = ferr_pulses; h0 = handshakes;
        send_byte(8'hA5, 1'b0);
        bit_out(1'b0);
        bit_out(1'b1);
        check("ferr_pulse", 64'(ferr_pulses - f0), 64'd1);
        check("ferr_no_byte", 64'(byte_pulses - b0), 64'd0);
        exp_words.push_back({2'd1, 32'h4433_2211});
        send_good(8'h11);
        check("ferr_next_byte", {56'd0, rx_byte}, 64'h11);
        send_good(8'h22); send_good(8'h33); send_good(8'h44);
        repeat (4) @(posedge clk); #1;
        check("ferr_word_handshakes", 64'(handshakes - h0), 64'd1);

        // Overrun: consumer stalled across two words.
        pulse_load();
        wr_ready = 1'b0;
        h0 = handshakes;
        exp_words.push_back({2'd0, 32'h0403_0201});
        for (int i = 1; i <= 8; i++) send_good(8'(i));
        repeat (4) @(posedge clk); #1;
        check("ovr_pending", {31'd0, wr_valid, overrun, wr_addr, wr_data}, {31'd1, 1'b1, 2'd0, 32'h0403_0201});
        wr_ready = 1'b1;
        @(posedge clk); #1;
        check("ovr_valid_drop", {63'd0, wr_valid}, 64'd0);
        repeat (2) @(posedge clk); #1;
        check("ovr_one_handshake", 64'(handshakes - h0), 64'd1);
        check("ovr_sticky", {63'd0, overrun}, 64'd1);
        pulse_load();
        check("ovr_cleared", {63'd0, overrun}, 64'd0);

        // Address wrap across five words.
        h0 = handshakes;
        for (int w = 0; w < 5; w++) begin
            exp_words.push_back({AW'(w), 8'(8'h43 + 4 * w), 8'(8'h42 + 4 * w), 8'(8'h41 + 4 * w), 8'(8'h40 + 4 * w)});
            for (int k = 0; k < 4; k++) send_good(8'(8'h40 + 4 * w + k));
        end
        repeat (4) @(posedge clk); #1;
        check("wrap_handshakes", 64'(handshakes - h0), 64'd5);

        // Reset in the middle of data bit 4, then a fresh byte at phase 0 of address 0.
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b0);
        repeat (DIV / 2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        check_all_zero("midreset");
        rx = 1'b1;
        repeat (2 * DIV) @(posedge clk); #1;
        reset_n = 1'b1;
        bit_out(1'b1);
        h0 = handshakes;
        exp_words.push_back({2'd0, 32'h9988_773C});
        send_good(8'h3C);
        check("midreset_byte", {55'd0, wr_valid, rx_byte}, {55'd0, 1'b0, 8'h3C});
        send_good(8'h77); send_good(8'h88); send_good(8'h99);
        repeat (4) @(posedge clk); #1;
        check("midreset_handshakes", 64'(handshakes - h0), 64'd1);

        check("bytes_drained", 64'(exp_bytes.size()), 64'd0);
        check("words_drained", 64'(exp_words.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_loader.md
# uart_rx_loader

Serial program loader for the board's `rx` pin. It receives 8N1 UART bytes and packs every four bytes little-endian into a 32-bit word. Each word is presented on a valid/ready write port with an auto-incrementing word address, for MCU memory or a debug buffer. It is the receive counterpart to the MCU serial transmitter, and it also exposes each received byte for display on the board's 7-segment show mode.

## Interface
Parameters:
- `CLK_FREQUENCY`, default 50000000: clk frequency in Hz.
- `BAUD_RATE`, default 115200: serial bit rate.
- `ADDR_WIDTH`, default 12: width of the word address.

Ports:
- `clk` input 1: clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `rx` input 1: raw asynchronous serial input; idle high.
- `load_start` input 1: one-cycle pulse; clears address, byte phase and overrun.
- `wr_valid` output 1: write word pending.
- `wr_ready` input 1: consumer accepts the word.
- `wr_addr` output ADDR_WIDTH: word address of the pending word.
- `wr_data` output 32: pending word.
- `rx_byte` output 8: last good byte received.
- `rx_byte_valid` output 1: one-cycle pulse when `rx_byte` updates.
- `frame_err` output 1: one-cycle pulse on a bad stop bit.
- `overrun` output 1: sticky; a word was lost.
- `busy` output 1: receiver FSM not in IDLE, or `wr_valid` high.

## Operation
- **Bit period:** DIV = CLK_FREQUENCY / BAUD_RATE, integer truncation (434 at the defaults). Half-period is DIV/2.
- **Synchronizer:** `rx` passes through a 2-flop synchronizer; all logic uses the synchronized value.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on synchronized rx = 0, go to START and load the counter with DIV/2.
  - START: at counter expiry, sample rx. If 0, go to DATA with bit index 0 and counter DIV. If 1, treat as a glitch and return to IDLE.
  - DATA: at each expiry, shift in the rx sample LSB first. After the 8th bit, go to STOP.
  - STOP: at expiry, sample rx.
    - If 1: the byte is good. Pulse `rx_byte_valid`, update `rx_byte`, hand the byte to the assembler, go to IDLE.
    - If 0: pulse `frame_err`, discard the byte (no assembler change), go to WAIT_HIGH.
  - WAIT_HIGH: stay until synchronized rx = 1, then go to IDLE.
- **Assembler:** 2-bit phase p and a 32-bit shift buffer.
  - Good byte b: buffer[8p+7:8p] = b, p increments.
  - On the byte with p = 3: the completed word moves to the output register. `wr_data` takes the word, `wr_addr` takes the current address, `wr_valid` = 1. p wraps to 0.
- **Write handshake:**
  - `wr_valid` stays high, with `wr_data`/`wr_addr` stable, until a cycle with `wr_valid & wr_ready`.
  - On that cycle `wr_valid` drops and the address increments, wrapping from 2^ADDR_WIDTH−1 to 0.
  - Assembly of the next word continues while `wr_valid` is held.
- **Overrun:** a word completes while `wr_valid` is still high and no handshake occurs that cycle.
  - The new word is dropped; the output register is unchanged; `overrun` is set.
  - The address does not advance for the dropped word.
  - If the handshake and the completion fall in the same cycle, the new word is loaded (with the incremented address) and there is no overrun.
- **`load_start`:** clears the address, p, the buffer, `wr_valid` and `overrun`. It does not disturb an in-flight serial byte; that byte lands as byte 0 of address 0. `load_start` has priority over a simultaneous handshake or word completion.
- **Reset values:** all outputs 0, `rx_byte` = 0x00, FSM in IDLE. The synchronizer flops reset to 1, so a mid-byte reset followed by a low line is treated as a new start edge.

## Timing
- Start sample falls DIV/2 cycles after the synchronized falling edge. Each later sample is DIV cycles after the previous one.
- `rx_byte_valid`/`frame_err` pulse on the cycle after the stop-bit sample.
- `wr_valid` rises on the same cycle as the `rx_byte_valid` of the 4th byte.
- Latency from the pin's falling edge to the start decision: 2 synchronizer cycles plus DIV/2.
- The `wr_ready` → `wr_valid` drop is registered: `wr_valid` is low on the next cycle.
- `frame_err` and `rx_byte_valid` are never high together.

## Test plan
- **Single word:** send 0x78, 0x56, 0x34, 0x12 with `wr_ready` = 1 → exactly one handshake, `wr_data` = 0x12345678, `wr_addr` = 0, four `rx_byte_valid` pulses, next `wr_addr` = 1.
- **Start-bit glitch:** rx low for 100 cycles, then high (defaults) → no `rx_byte_valid`, no `frame_err`, FSM back in IDLE.
- **Framing error:** byte 0xA5 with stop bit 0, held low 2 bit periods, then 0x11 sent normally → one `frame_err` pulse, `rx_byte` = 0x11, phase advanced by 1 only.
- **Overrun:** `wr_ready` = 0 while 8 bytes 0x01..0x08 are sent → `wr_data` = 0x04030201, `overrun` = 1. Raise `wr_ready` → one handshake at addr 0. `load_start` → `overrun` = 0.
- **Wrap:** ADDR_WIDTH = 2, five words with `wr_ready` = 1 → addresses 0, 1, 2, 3, 0.
- **Mid-byte reset:** assert `reset_n` = 0 during DATA bit 4, release, send 0x3C → all outputs 0 during reset, then `rx_byte` = 0x3C, phase 1, `wr_valid` = 0.
